// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer slice.
// Holds the default widths and timing, the FSM state encoding, and the
// masked-compare function used at check time.
package vector_sequencer_pkg;

    localparam int unsigned DEF_IN_W          = 8;
    localparam int unsigned DEF_OUT_W         = 6;
    localparam int unsigned DEF_DEPTH         = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 10;
    localparam int unsigned DEF_GAP_CYCLES    = 4;

    // Widest DUT output the compare function accepts; callers zero-extend.
    localparam int unsigned MAX_OUT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A vector fails when any bit selected by the mask differs from expected.
    function automatic logic check_mismatch(
        input logic [MAX_OUT_W-1:0] out_v,
        input logic [MAX_OUT_W-1:0] exp_v,
        input logic [MAX_OUT_W-1:0] mask_v
    );
        return |((out_v ^ exp_v) & mask_v);
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Bus bundle between a host/DUT harness and the vector sequencer.
// master: drives configuration, start and the DUT output; observes results.
// slave : the sequencer itself.
//   cfg_we/cfg_addr/cfg_in/cfg_exp/cfg_mask  vector storage write port
//   num_vectors/start                        run control
//   dut_out / dut_in                         DUT response / DUT stimulus
//   busy/done/pass/err_count/first_err_*     run status and results
//   log_valid/log_idx/log_out/log_err        per-vector log stream
interface vector_sequencer_if
    import vector_sequencer_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [IN_W-1:0]  cfg_in;
    logic [OUT_W-1:0] cfg_exp;
    logic [OUT_W-1:0] cfg_mask;
    logic [AW:0]      num_vectors;
    logic             start;
    logic [OUT_W-1:0] dut_out;

    logic [IN_W-1:0]  dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [AW:0]      err_count;
    logic             first_err_valid;
    logic [AW-1:0]    first_err_idx;
    logic             log_valid;
    logic [AW-1:0]    log_idx;
    logic [OUT_W-1:0] log_out;
    logic             log_err;

    modport master (
        output cfg_we, cfg_addr, cfg_in, cfg_exp, cfg_mask, num_vectors, start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx,
               log_valid, log_idx, log_out, log_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_in, cfg_exp, cfg_mask, num_vectors, start, dut_out,
        output dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx,
               log_valid, log_idx, log_out, log_err
    );

endinterface

// File: rtl/vector_sequencer_mem.sv
// Vector storage: DEPTH entries of {stimulus, expected, mask}.
// One synchronous write port, one asynchronous read port, no reset.
//   clk                          write clock
//   i_we/i_waddr                 write enable and entry index
//   i_win/i_wexp/i_wmask         entry fields to store
//   i_raddr                      read index
//   o_rin/o_rexp/o_rmask         entry fields at i_raddr
module vector_sequencer_mem #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 6,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [IN_W-1:0]            i_win,
    input  logic [OUT_W-1:0]           i_wexp,
    input  logic [OUT_W-1:0]           i_wmask,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [IN_W-1:0]            o_rin,
    output logic [OUT_W-1:0]           o_rexp,
    output logic [OUT_W-1:0]           o_rmask
);
    localparam int unsigned W = IN_W + 2 * OUT_W;

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] w_rd;

    // Write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_win, i_wexp, i_wmask};
        end
    end

    // Asynchronous read, split back into fields.
    assign w_rd    = r_mem[i_raddr];
    assign o_rin   = w_rd[W-1 -: IN_W];
    assign o_rexp  = w_rd[2*OUT_W-1 -: OUT_W];
    assign o_rmask = w_rd[OUT_W-1:0];

endmodule

// File: rtl/vector_sequencer.sv
// Vector sequencer: plays stored {input, expected, mask} vectors into a
// combinational DUT, waits a settle window, checks the masked response,
// logs it, idles a gap, and accumulates run results.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus (slave)  configuration, run control, DUT stimulus/response,
//                status, results and per-vector log
// SETTLE_CYCLES must be >= 1; GAP_CYCLES = 0 skips the gap entirely.
// DEPTH must be a power of two >= 2.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int unsigned IN_W          = DEF_IN_W,
    parameter int unsigned OUT_W         = DEF_OUT_W,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    vector_sequencer_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned NW      = AW + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [NW-1:0]    r_n;
    logic [CW-1:0]    r_cnt;
    logic [IN_W-1:0]  r_dut_in;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [NW-1:0]    r_err_count;
    logic             r_first_err_valid;
    logic [AW-1:0]    r_first_err_idx;
    logic             r_log_valid;
    logic [AW-1:0]    r_log_idx;
    logic [OUT_W-1:0] r_log_out;
    logic             r_log_err;

    logic             w_idle_like;
    logic             w_mem_we;
    logic [NW-1:0]    w_n_clamped;
    logic             w_last;
    logic             w_mismatch;
    logic [NW-1:0]    w_err_next;
    logic [IN_W-1:0]  w_rd_in;
    logic [OUT_W-1:0] w_rd_exp;
    logic [OUT_W-1:0] w_rd_mask;

    // Storage is only writable between runs so a run never sees partial updates.
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_mem_we    = bus.cfg_we && w_idle_like;

    assign w_n_clamped = (bus.num_vectors > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_vectors;
    assign w_last      = ({1'b0, r_idx} == (r_n - NW'(1)));
    assign w_mismatch  = check_mismatch(MAX_OUT_W'(bus.dut_out),
                                        MAX_OUT_W'(w_rd_exp),
                                        MAX_OUT_W'(w_rd_mask));
    assign w_err_next  = (&r_err_count) ? r_err_count : r_err_count + NW'(1);

    vector_sequencer_mem #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.cfg_addr),
        .i_win   (bus.cfg_in),
        .i_wexp  (bus.cfg_exp),
        .i_wmask (bus.cfg_mask),
        .i_raddr (r_idx),
        .o_rin   (w_rd_in),
        .o_rexp  (w_rd_exp),
        .o_rmask (w_rd_mask)
    );

    // Sequencing FSM with all status and log outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_idx             <= '0;
            r_n               <= '0;
            r_cnt             <= '0;
            r_dut_in          <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_log_valid       <= 1'b0;
            r_log_idx         <= '0;
            r_log_out         <= '0;
            r_log_err         <= 1'b0;
        end else begin
            r_log_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_n               <= w_n_clamped;
                        r_idx             <= '0;
                        r_err_count       <= '0;
                        r_first_err_valid <= 1'b0;
                        r_first_err_idx   <= '0;
                        if (w_n_clamped == '0) begin
                            // Empty run: trivially passes.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_APPLY;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_APPLY: begin
                    r_dut_in <= w_rd_in;
                    r_cnt    <= CW'(SETTLE_CYCLES - 1);
                    r_state  <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                ST_CHECK: begin
                    r_log_valid <= 1'b1;
                    r_log_idx   <= r_idx;
                    r_log_out   <= bus.dut_out;
                    r_log_err   <= w_mismatch;
                    if (w_mismatch) begin
                        r_err_count <= w_err_next;
                        if (!r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_idx   <= r_idx;
                        end
                    end
                    if (GAP_CYCLES != 0) begin
                        r_cnt   <= CW'(GAP_CYCLES - 1);
                        r_state <= ST_GAP;
                    end else if (w_last) begin
                        // No gap: this check's own result decides pass.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_count == '0) && !w_mismatch;
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= ST_APPLY;
                    end
                end

                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_count == '0);
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= ST_APPLY;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_in          = r_dut_in;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.first_err_idx   = r_first_err_idx;
    assign bus.log_valid       = r_log_valid;
    assign bus.log_idx         = r_log_idx;
    assign bus.log_out         = r_log_out;
    assign bus.log_err         = r_log_err;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: two instances (gap of 4 and gap of 0) run the
// same stored vectors against a combinational DUT model dut_out = in[5:0] ^ flip.
module tb_vector_sequencer;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned OUT_W  = 6;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned NW     = AW + 1;
    localparam int unsigned SETTLE = 10;
    localparam int unsigned GAP0   = 4;
    localparam int unsigned GAP1   = 0;

    typedef struct {
        int               rel;
        int               idx;
        logic [OUT_W-1:0] o;
        logic             e;
    } log_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    logic             tb_cfg_we      = 1'b0;
    logic [AW-1:0]    tb_cfg_addr    = '0;
    logic [IN_W-1:0]  tb_cfg_in      = '0;
    logic [OUT_W-1:0] tb_cfg_exp     = '0;
    logic [OUT_W-1:0] tb_cfg_mask    = '0;
    logic [NW-1:0]    tb_num_vectors = '0;
    logic             tb_start       = 1'b0;
    logic [OUT_W-1:0] flip           = '0;

    // Reference copy of vector storage.
    logic [IN_W-1:0]  m_in   [DEPTH];
    logic [OUT_W-1:0] m_exp  [DEPTH];
    logic [OUT_W-1:0] m_mask [DEPTH];

    log_t lq0[$];
    log_t lq1[$];

    vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) vif0();
    vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) vif1();

    assign vif0.cfg_we      = tb_cfg_we;
    assign vif0.cfg_addr    = tb_cfg_addr;
    assign vif0.cfg_in      = tb_cfg_in;
    assign vif0.cfg_exp     = tb_cfg_exp;
    assign vif0.cfg_mask    = tb_cfg_mask;
    assign vif0.num_vectors = tb_num_vectors;
    assign vif0.start       = tb_start;
    assign vif0.dut_out     = vif0.dut_in[OUT_W-1:0] ^ flip;

    assign vif1.cfg_we      = tb_cfg_we;
    assign vif1.cfg_addr    = tb_cfg_addr;
    assign vif1.cfg_in      = tb_cfg_in;
    assign vif1.cfg_exp     = tb_cfg_exp;
    assign vif1.cfg_mask    = tb_cfg_mask;
    assign vif1.num_vectors = tb_num_vectors;
    assign vif1.start       = tb_start;
    assign vif1.dut_out     = vif1.dut_in[OUT_W-1:0] ^ flip;

    vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif0.slave)
    );

    vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture log pulses with their cycle offset from the start request.
    always @(negedge clk) begin
        if (vif0.log_valid)
            lq0.push_back('{rel: cyc - start_cyc, idx: int'(vif0.log_idx), o: vif0.log_out, e: vif0.log_err});
        if (vif1.log_valid)
            lq1.push_back('{rel: cyc - start_cyc, idx: int'(vif1.log_idx), o: vif1.log_out, e: vif1.log_err});
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " dut0 outputs"},
            {vif0.dut_in, vif0.busy, vif0.done, vif0.pass, vif0.err_count, vif0.first_err_valid,
             vif0.first_err_idx, vif0.log_valid, vif0.log_idx, vif0.log_out, vif0.log_err}, '0);
        chk({tag, " dut1 outputs"},
            {vif1.dut_in, vif1.busy, vif1.done, vif1.pass, vif1.err_count, vif1.first_err_valid,
             vif1.first_err_idx, vif1.log_valid, vif1.log_idx, vif1.log_out, vif1.log_err}, '0);
    endtask

    task automatic load(input int a, input logic [IN_W-1:0] vin,
                        input logic [OUT_W-1:0] vexp, input logic [OUT_W-1:0] vmask);
        m_in[a]   = vin;
        m_exp[a]  = vexp;
        m_mask[a] = vmask;
        @(negedge clk);
        tb_cfg_we   = 1'b1;
        tb_cfg_addr = AW'(a);
        tb_cfg_in   = vin;
        tb_cfg_exp  = vexp;
        tb_cfg_mask = vmask;
        @(negedge clk);
        tb_cfg_we = 1'b0;
    endtask

    task automatic check_logs(input string tag, input log_t q[$], input log_t expq[$],
                              input int cnt, input int period);
        chk({tag, " log count"}, q.size(), cnt);
        for (int k = 0; k < cnt && k < q.size(); k++) begin
            chk($sformatf("%s log%0d idx", tag, k), q[k].idx, expq[k].idx);
            chk($sformatf("%s log%0d out", tag, k), q[k].o, expq[k].o);
            chk($sformatf("%s log%0d err", tag, k), q[k].e, expq[k].e);
            // start edge + APPLY + settle window + check edge, then one period per vector
            chk($sformatf("%s log%0d time", tag, k), q[k].rel, 3 + SETTLE + k * period);
        end
    endtask

    // mode 0: plain run; 1: poke cfg_we/start mid-settle; 2: reset in CHECK of vector 2.
    task automatic run_check(input string tag, input int nv, input int mode);
        int   n, errs, first, rel;
        bit   fin;
        logic [OUT_W-1:0] o;
        logic e;
        log_t expq[$];

        n     = (nv > int'(DEPTH)) ? int'(DEPTH) : nv;
        errs  = 0;
        first = 0;
        for (int k = 0; k < n; k++) begin
            o = m_in[k][OUT_W-1:0] ^ flip;
            e = |((o ^ m_exp[k]) & m_mask[k]);
            if (e && errs == 0) first = k;
            if (e) errs++;
            expq.push_back('{rel: 0, idx: k, o: o, e: e});
        end

        lq0.delete();
        lq1.delete();
        @(negedge clk);
        tb_num_vectors = NW'(nv);
        tb_start       = 1'b1;
        start_cyc      = cyc;
        fin            = 1'b0;
        for (int c = 0; c < 700 && !fin; c++) begin
            @(negedge clk);
            tb_start  = 1'b0;
            tb_cfg_we = 1'b0;
            rel = cyc - start_cyc;
            if (rel == 5 && n > 0) begin
                chk({tag, " busy0 mid-run"}, vif0.busy, 1);
                chk({tag, " busy1 mid-run"}, vif1.busy, 1);
                chk({tag, " done0 mid-run"}, vif0.done, 0);
            end
            if (mode == 1 && rel == 5) begin
                tb_cfg_we      = 1'b1;
                tb_cfg_addr    = '0;
                tb_cfg_in      = ~m_in[0];
                tb_cfg_exp     = ~m_exp[0];
                tb_cfg_mask    = ~m_mask[0];
                tb_num_vectors = NW'(1);
                tb_start       = 1'b1;
            end
            if (mode == 2 && rel == 44) begin
                rst_n = 1'b0;
                fin   = 1'b1;
            end
            if (vif0.done && vif1.done) fin = 1'b1;
        end
        chk({tag, " run finished in bound"}, fin, 1);
        @(negedge clk);

        check_logs({tag, " dut0"}, lq0, expq, (mode == 2) ? 2 : n, 2 + SETTLE + GAP0);
        check_logs({tag, " dut1"}, lq1, expq, n, 2 + SETTLE + GAP1);

        if (mode == 2) begin
            check_zero({tag, " after abort"});
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk({tag, " dut0 done"}, vif0.done, 1);
            chk({tag, " dut1 done"}, vif1.done, 1);
            chk({tag, " dut0 busy"}, vif0.busy, 0);
            chk({tag, " dut0 err_count"}, vif0.err_count, errs);
            chk({tag, " dut1 err_count"}, vif1.err_count, errs);
            chk({tag, " dut0 pass"}, vif0.pass, errs == 0);
            chk({tag, " dut1 pass"}, vif1.pass, errs == 0);
            chk({tag, " dut0 first_err_valid"}, vif0.first_err_valid, errs > 0);
            chk({tag, " dut1 first_err_valid"}, vif1.first_err_valid, errs > 0);
            chk({tag, " dut0 first_err_idx"}, vif0.first_err_idx, first);
            chk({tag, " dut1 first_err_idx"}, vif1.first_err_idx, first);
            if (n > 0) begin
                chk({tag, " dut0 dut_in held"}, vif0.dut_in, m_in[n-1]);
                chk({tag, " dut1 dut_in held"}, vif1.dut_in, m_in[n-1]);
            end
        end
    endtask

    initial begin
        logic [IN_W-1:0] v;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Empty run finishes immediately with pass.
        run_check("n0", 0, 0);

        // Three matching vectors.
        for (int a = 0; a < 3; a++) begin
            v = IN_W'($urandom);
            load(a, v, v[OUT_W-1:0], OUT_W'($urandom) | OUT_W'(1));
        end
        run_check("basic", 3, 0);

        // Vector 1 checks only bit0, which the DUT drives low against an expected 1.
        load(1, m_in[1] & 8'hFE, 6'h3F, 6'h01);
        run_check("bit0", 3, 0);

        // Same vector fully masked.
        load(1, m_in[1], 6'h3F, 6'h00);
        run_check("masked", 3, 0);

        // Mid-run write/start are dropped; a rerun from DONE starts clean.
        load(1, m_in[1], 6'h3F, 6'h01);
        run_check("poke", 3, 1);
        run_check("rerun", 3, 0);

        // Reset during the check of vector 2.
        run_check("abort", 3, 2);

        // Randomized contents, DUT corruption and run lengths (first one over DEPTH).
        for (int r = 0; r < 4; r++) begin
            flip = OUT_W'($urandom_range(0, 3));
            for (int a = 0; a < int'(DEPTH); a++) begin
                v = IN_W'($urandom);
                if ($urandom_range(0, 1) == 1)
                    load(a, v, v[OUT_W-1:0], OUT_W'($urandom));
                else
                    load(a, v, OUT_W'($urandom), OUT_W'($urandom));
            end
            run_check($sformatf("rand%0d", r), (r == 0) ? 20 : int'($urandom_range(1, DEPTH)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
